// File: rtl/gpu_fb_pkg.sv
// Shared framebuffer geometry, fragment record and FSM encoding for the GPU
// fragment write path.
package gpu_fb_pkg;

    localparam int FB_WIDTH_DEF  = 320;
    localparam int FB_HEIGHT_DEF = 240;
    localparam int FB_PIXELS     = FB_WIDTH_DEF * FB_HEIGHT_DEF;

    localparam int ADDR_W  = 18;
    localparam int COORD_W = 10;
    localparam int CH_W    = 4;
    localparam int COLOR_W = 3 * CH_W;
    localparam int DATA_W  = 16;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] color;
    } frag_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } fb_state_t;

    function automatic logic [DATA_W-1:0] pack_rgb444(input logic [COLOR_W-1:0] c);
        return {{(DATA_W-COLOR_W){1'b0}}, c};
    endfunction

endpackage

// File: rtl/frag_fifo.sv
// Synchronous first-word-fall-through FIFO with a flush that empties it in
// one cycle; flush takes priority over a same-cycle push.
module frag_fifo #(
    parameter int WIDTH = 30,
    parameter int DEPTH = 16
) (
    input  logic             I_CLK,
    input  logic             I_RST_N,
    input  logic             I_FLUSH,
    input  logic             I_PUSH,
    input  logic             I_POP,
    input  logic [WIDTH-1:0] I_DATA,
    output logic [WIDTH-1:0] O_DATA,
    output logic             O_FULL,
    output logic             O_EMPTY
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // Extra pointer bit separates full from empty when the indices match.
    assign O_EMPTY = (wr_ptr == rd_ptr);
    assign O_FULL  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign O_DATA  = mem[rd_ptr[PW-1:0]];
    assign do_push = I_PUSH && !O_FULL && !I_FLUSH;
    assign do_pop  = I_POP && !O_EMPTY && !I_FLUSH;

    always_ff @(posedge I_CLK) begin
        if (!I_RST_N || I_FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= I_DATA;
    end

endmodule

// File: rtl/frag_fb_writer.sv
// Buffers rasterized fragments and writes them to the framebuffer during video
// blanking; also sweeps a full-screen clear.
module frag_fb_writer
    import gpu_fb_pkg::*;
#(
    parameter int FB_WIDTH   = FB_WIDTH_DEF,
    parameter int FB_HEIGHT  = FB_HEIGHT_DEF,
    parameter int FIFO_DEPTH = 16
) (
    input  logic               I_CLK,
    input  logic               I_RST_N,
    input  logic               I_FRAG_VALID,
    output logic               O_FRAG_READY,
    input  logic [COORD_W-1:0] I_FRAG_X,
    input  logic [COORD_W-1:0] I_FRAG_Y,
    input  logic [COLOR_W-1:0] I_FRAG_COLOR,
    input  logic               I_CLEAR,
    input  logic [COLOR_W-1:0] I_CLEAR_COLOR,
    input  logic               I_VIDEO_ON,
    output logic [ADDR_W-1:0]  O_GPU_ADDR,
    output logic [DATA_W-1:0]  O_GPU_DATA,
    output logic               O_GPU_WRITE,
    output logic               O_GPU_READ,
    output logic               O_BUSY,
    output logic [15:0]        O_DROP_COUNT
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_WIDTH * FB_HEIGHT - 1);

    fb_state_t          state, state_nxt;
    logic [ADDR_W-1:0]  clr_cnt;
    logic [COLOR_W-1:0] clr_color;
    logic [15:0]        drop_cnt;
    frag_t              push_frag, head_frag;
    logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic               accept, in_bounds, clear_step;

    assign O_FRAG_READY = !fifo_full && (state != ST_CLEAR);
    assign O_BUSY       = (state != ST_IDLE) || !fifo_empty;
    assign O_GPU_READ   = 1'b0;
    assign O_DROP_COUNT = drop_cnt;

    assign accept    = I_FRAG_VALID && O_FRAG_READY;
    assign in_bounds = (32'(I_FRAG_X) < 32'(FB_WIDTH)) && (32'(I_FRAG_Y) < 32'(FB_HEIGHT));
    assign push_frag = '{addr:  ADDR_W'(I_FRAG_Y) * ADDR_W'(FB_WIDTH) + ADDR_W'(I_FRAG_X),
                         color: I_FRAG_COLOR};
    assign fifo_push = accept && in_bounds;
    // A clear request in any state outranks both the drain and the clear sweep.
    assign fifo_pop   = (state == ST_DRAIN) && !I_CLEAR && !I_VIDEO_ON && !fifo_empty;
    assign clear_step = (state == ST_CLEAR) && !I_CLEAR && !I_VIDEO_ON;

    frag_fifo #(
        .WIDTH ($bits(frag_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .I_CLK   (I_CLK),
        .I_RST_N (I_RST_N),
        .I_FLUSH (I_CLEAR),
        .I_PUSH  (fifo_push),
        .I_POP   (fifo_pop),
        .I_DATA  (push_frag),
        .O_DATA  (head_frag),
        .O_FULL  (fifo_full),
        .O_EMPTY (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (I_CLEAR)          state_nxt = ST_CLEAR;
                else if (!fifo_empty) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (I_CLEAR)         state_nxt = ST_CLEAR;
                else if (fifo_empty) state_nxt = ST_IDLE;
            end
            ST_CLEAR: begin
                if (clear_step && clr_cnt == LAST_ADDR) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK) begin
        if (!I_RST_N) begin
            state       <= ST_IDLE;
            clr_cnt     <= '0;
            clr_color   <= '0;
            drop_cnt    <= '0;
            O_GPU_ADDR  <= '0;
            O_GPU_DATA  <= '0;
            O_GPU_WRITE <= 1'b0;
        end else begin
            state       <= state_nxt;
            O_GPU_WRITE <= fifo_pop || clear_step;
            if (fifo_pop) begin
                O_GPU_ADDR <= head_frag.addr;
                O_GPU_DATA <= pack_rgb444(head_frag.color);
            end else if (clear_step) begin
                O_GPU_ADDR <= clr_cnt;
                O_GPU_DATA <= pack_rgb444(clr_color);
            end
            if (I_CLEAR) begin
                clr_color <= I_CLEAR_COLOR;
                clr_cnt   <= '0;
            end else if (clear_step) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
            if (accept && !in_bounds && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_frag_fb_writer.sv
// Directed bench for frag_fb_writer: handshake, latency, bounds/drop counter,
// full clear with pause, flush on clear, and reset mid-clear.
module tb_frag_fb_writer;
    import gpu_fb_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        frag_valid = 1'b0, clear = 1'b0, video_on = 1'b0;
    logic [9:0]  fx = '0, fy = '0;
    logic [11:0] fc = '0, clr_c = '0;
    logic        frag_ready, gpu_write, gpu_read, busy;
    logic [17:0] gpu_addr;
    logic [15:0] gpu_data, drop;

    int   n_chk = 0, n_err = 0, cyc = 0, viol = 0;
    logic vid_q = 1'b0;

    typedef struct {
        logic [17:0] a;
        logic [15:0] d;
        int          c;
    } wr_t;
    wr_t wq[$];

    frag_fb_writer dut (
        .I_CLK         (clk),
        .I_RST_N       (rst_n),
        .I_FRAG_VALID  (frag_valid),
        .O_FRAG_READY  (frag_ready),
        .I_FRAG_X      (fx),
        .I_FRAG_Y      (fy),
        .I_FRAG_COLOR  (fc),
        .I_CLEAR       (clear),
        .I_CLEAR_COLOR (clr_c),
        .I_VIDEO_ON    (video_on),
        .O_GPU_ADDR    (gpu_addr),
        .O_GPU_DATA    (gpu_data),
        .O_GPU_WRITE   (gpu_write),
        .O_GPU_READ    (gpu_read),
        .O_BUSY        (busy),
        .O_DROP_COUNT  (drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        vid_q <= video_on;
    end

    // Write log plus a watch for any strobe following a video-on sample.
    always @(negedge clk) begin
        if (gpu_write === 1'b1) begin
            wq.push_back('{gpu_addr, gpu_data, cyc});
            if (vid_q) viol++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_frag(input logic [9:0] x, input logic [9:0] y, input logic [11:0] c);
        int t;
        fx = x; fy = y; fc = c; frag_valid = 1'b1;
        t = 0;
        while (!frag_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("send_timeout", 32'(t), 32'd0);
        @(negedge clk);
        frag_valid = 1'b0;
    endtask

    initial begin
        int t, bad, gaps;

        // Reset state
        step(3);
        chk("rst_write", 32'(gpu_write), 32'd0);
        chk("rst_addr",  32'(gpu_addr),  32'd0);
        chk("rst_data",  32'(gpu_data),  32'd0);
        chk("rst_drop",  32'(drop),      32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_ready", 32'(frag_ready), 32'd1);
        chk("rst_read",  32'(gpu_read),  32'd0);
        rst_n = 1'b1;
        step(1);

        // Single fragment latency: write in the cycle after edge N+2
        send_frag(10'd5, 10'd2, 12'hF0A);
        chk("t1_wr_n0", 32'(gpu_write), 32'd0);
        step(1);
        chk("t1_wr_n1", 32'(gpu_write), 32'd0);
        step(1);
        chk("t1_wr_n2", 32'(gpu_write), 32'd1);
        chk("t1_addr",  32'(gpu_addr),  32'd645);
        chk("t1_data",  32'(gpu_data),  32'h0F0A);
        step(1);
        chk("t1_wr_n3", 32'(gpu_write), 32'd0);
        chk("t1_busy",  32'(busy),      32'd0);

        // Fill FIFO during scan, then drain in order at one per cycle
        wq.delete();
        video_on = 1'b1;
        for (int i = 0; i < 16; i++) send_frag(10'(10 + i), 10'd1, 12'(12'h100 + i));
        chk("t2_ready_full", 32'(frag_ready), 32'd0);
        step(5);
        #1;
        chk("t2_no_write", 32'(wq.size()), 32'd0);
        video_on = 1'b0;
        step(1);
        chk("t2_first_wr",   32'(gpu_write), 32'd1);
        chk("t2_first_addr", 32'(gpu_addr),  32'd330);
        chk("t2_ready_back", 32'(frag_ready), 32'd1);
        step(20);
        #1;
        chk("t2_count", 32'(wq.size()), 32'd16);
        bad = 0;
        for (int i = 0; i < wq.size(); i++)
            if (wq[i].a !== 18'(330 + i) || wq[i].d !== 16'(16'h0100 + i)) bad++;
        chk("t2_order", 32'(bad), 32'd0);
        if (wq.size() == 16) chk("t2_span", 32'(wq[15].c - wq[0].c), 32'd15);
        chk("t2_busy", 32'(busy), 32'd0);

        // Out-of-bounds fragments and drop counter saturation
        wq.delete();
        send_frag(10'd320, 10'd0, 12'hFFF);
        send_frag(10'd0, 10'd240, 12'hFFF);
        step(5);
        #1;
        chk("t3_no_write", 32'(wq.size()), 32'd0);
        chk("t3_drop2",    32'(drop),      32'd2);
        @(negedge clk);
        force dut.drop_cnt = 16'hFFFF;
        send_frag(10'd400, 10'd10, 12'h123);
        release dut.drop_cnt;
        step(1);
        chk("t3_sat1", 32'(drop), 32'hFFFF);
        send_frag(10'd1000, 10'd1000, 12'h123);
        step(1);
        chk("t3_sat2", 32'(drop), 32'hFFFF);

        // Full clear with a pause in the middle
        wq.delete();
        clr_c = 12'h00F;
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("t4_ready_clr", 32'(frag_ready), 32'd0);
        step(1000);
        video_on = 1'b1;
        step(7);
        video_on = 1'b0;
        t = 0;
        while (busy && t < 90000) begin
            step(1);
            t++;
        end
        chk("t4_done_timeout", 32'(t < 90000), 32'd1);
        step(2);
        #1;
        chk("t4_count", 32'(wq.size()), 32'd76800);
        bad = 0;
        gaps = 0;
        for (int i = 0; i < wq.size(); i++) begin
            if (wq[i].a !== 18'(i) || wq[i].d !== 16'h000F) bad++;
            if (i > 0 && wq[i].c != wq[i-1].c + 1) gaps++;
        end
        chk("t4_seq",   32'(bad),  32'd0);
        chk("t4_pause", 32'(gaps), 32'd1);
        chk("t4_ready_after", 32'(frag_ready), 32'd1);

        // Queued fragments flushed by clear, then reset at counter=100
        wq.delete();
        video_on = 1'b1;
        send_frag(10'd1, 10'd0, 12'hABC);
        send_frag(10'd2, 10'd0, 12'hABC);
        send_frag(10'd3, 10'd0, 12'hABC);
        clr_c = 12'h0F0;
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        chk("t5_ready_clr", 32'(frag_ready), 32'd0);
        chk("t5_busy",      32'(busy),       32'd1);
        video_on = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            #1;
            t++;
        end while (wq.size() < 100 && t < 500);
        chk("t5_wait_timeout", 32'(t < 500), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_write", 32'(gpu_write),  32'd0);
        chk("t6_ready", 32'(frag_ready), 32'd1);
        chk("t6_drop",  32'(drop),       32'd0);
        chk("t6_busy",  32'(busy),       32'd0);
        chk("t6_state", 32'(dut.state),  32'(ST_IDLE));
        #1;
        chk("t5_count", 32'(wq.size()), 32'd100);
        bad = 0;
        for (int i = 0; i < wq.size(); i++)
            if (wq[i].a !== 18'(i) || wq[i].d !== 16'h00F0) bad++;
        chk("t5_flushed", 32'(bad), 32'd0);
        rst_n = 1'b1;
        step(2);

        chk("video_guard", 32'(viol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/frag_fb_writer.md
Name: frag_fb_writer

Overview:
- Sits directly downstream of the rasterizer and upstream of the framebuffer SRAM arbiter (GPU side of the multi-port SRAM).
- Accepts rasterized fragments (x, y, 12-bit RGB) over a valid/ready handshake and buffers them in a FIFO.
- Converts each fragment to a linear framebuffer address and issues single-cycle writes, only while the video scan is off.
- Also performs a full-screen clear to a given colour on request.

Parameters:
- FB_WIDTH, 320, framebuffer width in pixels.
- FB_HEIGHT, 240, framebuffer height in pixels.
- FIFO_DEPTH, 16, fragment FIFO entries (power of 2).

Ports:
- I_CLK  in  1  GPU clock.
- I_RST_N  in  1  synchronous active-low reset.
- I_FRAG_VALID  in  1  fragment valid from rasterizer.
- O_FRAG_READY  out  1  = !fifo_full && state!=CLEAR.
- I_FRAG_X  in  10  pixel x.
- I_FRAG_Y  in  10  pixel y.
- I_FRAG_COLOR  in  12  {R[3:0],G[3:0],B[3:0]}.
- I_CLEAR  in  1  one-cycle clear request.
- I_CLEAR_COLOR  in  12  clear colour, sampled with I_CLEAR.
- I_VIDEO_ON  in  1  VGA scan active; no writes allowed while high.
- O_GPU_ADDR  out  18  framebuffer word address.
- O_GPU_DATA  out  16  {4'h0, colour}.
- O_GPU_WRITE  out  1  write strobe, one cycle per pixel.
- O_GPU_READ  out  1  constant 0.
- O_BUSY  out  1  high when state!=IDLE or FIFO non-empty.
- O_DROP_COUNT  out  16  saturating count of out-of-bounds fragments.

Behaviour:
- Reset (I_RST_N low at a rising edge):
  - state=IDLE, FIFO empty.
  - O_GPU_ADDR=0, O_GPU_DATA=0, O_GPU_WRITE=0.
  - O_DROP_COUNT=0, clear counter=0, O_BUSY=0.
  - Reset mid-write or mid-clear aborts immediately; FIFO contents are lost.
- Handshake:
  - A fragment transfers when I_FRAG_VALID && O_FRAG_READY at a rising edge.
  - Bounds check: x>=FB_WIDTH or y>=FB_HEIGHT means the fragment is accepted but discarded. O_DROP_COUNT increments and saturates at 16'hFFFF.
  - In-bounds fragments are pushed as {addr, colour}, with addr = y*FB_WIDTH + x computed at push. For 320 this is (y<<8)+(y<<6)+x, with an 18-bit result.
- FSM states IDLE, DRAIN, CLEAR. All GPU outputs are registered.
  - IDLE:
    - I_CLEAR goes to CLEAR. It latches the clear colour, zeroes the clear counter and flushes the FIFO.
    - Else, FIFO non-empty goes to DRAIN.
  - DRAIN:
    - Each cycle with !I_VIDEO_ON and FIFO non-empty: pop the head; the next cycle O_GPU_WRITE=1 with the head's addr/data.
    - While I_VIDEO_ON=1: O_GPU_WRITE=0 next cycle; FIFO and head are held.
    - FIFO empty returns to IDLE.
    - I_CLEAR goes to CLEAR as from IDLE; pending entries are discarded.
  - CLEAR:
    - Each cycle with !I_VIDEO_ON: write addr=counter, data=clear colour, then counter++.
    - I_VIDEO_ON pauses the sequence without losing position.
    - After address FB_WIDTH*FB_HEIGHT-1 is written, return to IDLE.
    - A new I_CLEAR during CLEAR restarts at address 0 with the new colour.
    - O_FRAG_READY=0 throughout.
- Simultaneous events:
  - I_CLEAR and an accepted fragment in the same cycle: the flush wins and the fragment is not written.
  - Push and pop in the same cycle with the FIFO full is impossible (ready=0). With the FIFO non-full, both occur and the count is unchanged.
- Latency:
  - Fragment accepted at edge N into an empty FIFO, with I_VIDEO_ON low: O_GPU_WRITE high during the cycle after edge N+2.
  - Sustained throughput: 1 pixel/cycle during blanking.
- O_GPU_WRITE is never high in a cycle following an edge where I_VIDEO_ON was sampled high.

Decomposition:
- Package gpu_fb_pkg:
  - FB_WIDTH/FB_HEIGHT defaults and FB_PIXELS.
  - Colour field widths.
  - Fragment struct {addr[17:0], color[11:0]}.
  - FSM state encoding.
  - Function pack_rgb444 to 16 bit.
- Sub-module frag_fifo: synchronous FIFO parameterised by width/depth with push, pop, full, empty, and the same I_CLK/I_RST_N.

Test Plan:
- Reset, then VIDEO_ON=0 and a fragment (x=5,y=2,color=12'hF0A) -> one write pulse, ADDR=645, DATA=16'h0F0A, two cycles after acceptance; O_BUSY falls afterwards.
- Push 16 fragments with VIDEO_ON=1 -> READY low after the 16th, no writes. Drop VIDEO_ON -> 16 consecutive writes in FIFO order, READY reasserts after the first pop.
- Fragments (x=320,y=0) and (x=0,y=240) -> no writes, O_DROP_COUNT=2. Force the counter to 16'hFFFF, send a further out-of-bounds fragment -> stays 16'hFFFF.
- I_CLEAR with colour 12'h00F, VIDEO_ON=0 -> 76800 writes, ADDR 0..76799, DATA=16'h000F. Toggle VIDEO_ON mid-clear -> writes pause and resume at the next address.
- 3 fragments queued, VIDEO_ON=1, then I_CLEAR -> FIFO flushed, the clear runs, and none of the 3 addresses receive fragment colour.
- Assert I_RST_N=0 mid-clear at counter=100 -> next cycle O_GPU_WRITE=0, state IDLE, READY=1, O_DROP_COUNT=0.
